// File: rtl/freq_mon_pkg.sv
// freq_mon_pkg: shared types and helpers for the frequency monitor.
//   state_e   - monitor FSM states
//   CNT_W_DEF - default counter / period width
//   abs_diff  - exact |a - b| without wrap (valid for widths up to 32 bits)
package freq_mon_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    TRACK  = 3'd2,
    LOCKED = 3'd3,
    FAULT  = 3'd4
  } state_e;

  // One extra bit of headroom over the operands so the subtraction never wraps;
  // callers zero-extend their CNT_W operands into the 32-bit inputs.
  function automatic logic [32:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    logic signed [32:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[32] ? $unsigned(-d) : $unsigned(d);
  endfunction

endpackage

// File: rtl/freq_monitor_sync_edge_det.sv
// sync_edge_det: SYNC_STAGES-deep synchronizer on sig_in plus a history flop;
// rise pulses for one clk cycle per synchronized rising edge.
// Ports: clk, rst (sync, active low), sig_in (async-ish input), rise (pulse).
module sync_edge_det
  import freq_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise
);

  // Fewer than two stages would not be a synchronizer at all.
  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [NS-1:0] sync_pipe;
  logic          prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_pipe <= '0;
      prev      <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[NS-2:0], sig_in};
      prev      <= sync_pipe[NS-1];
    end
  end

  assign rise = sync_pipe[NS-1] & ~prev;

endmodule

// File: rtl/freq_monitor.sv
// freq_monitor: measures the period of a divided clock (sig_in) in clk cycles,
// checks it against exp_period +/- tol, declares lock after LOCK_CNT good
// periods in a row and raises a sticky fault on a bad period or timeout
// once locked.
// Ports:
//   clk, rst (sync, active low)   clock / reset
//   en                            0 forces IDLE
//   clr_fault                     pulse, FAULT -> ARM
//   sig_in                        monitored divided clock
//   exp_period, tol [CNT_W]       expected period and allowed deviation
//   period [CNT_W], period_vld    last measurement + one-cycle strobe
//   locked, fault                 status (never both high)
// Optional (macro FREQ_MON_HIST_EN): min_period / max_period [CNT_W],
//   running extremes of reported periods, cleared on clr_fault or en=0.
module freq_monitor
  import freq_mon_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr_fault,
  input  logic             sig_in,
  input  logic [CNT_W-1:0] exp_period,
  input  logic [CNT_W-1:0] tol,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             locked,
  output logic             fault
`ifdef FREQ_MON_HIST_EN
  ,
  output logic [CNT_W-1:0] min_period,
  output logic [CNT_W-1:0] max_period
`endif
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0] LOCK_TGT = GW'(LOCK_CNT);

  state_e          state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [GW-1:0]   good_cnt, good_n;
  logic            rise, timeout, in_win, meas;
  logic [32:0]     diff;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .rise   (rise)
  );

  // Counter parks at all-ones; a rise in that same cycle still counts as a
  // valid period because rise is tested before timeout below.
  assign timeout = &cnt;
  assign diff    = abs_diff(32'(cnt), 32'(exp_period));
  assign in_win  = (diff <= 33'(tol));

  always_comb begin
    state_n = state;
    good_n  = good_cnt;
    meas    = 1'b0;
    if (!en) begin
      state_n = IDLE;
      good_n  = '0;
    end else begin
      case (state)
        IDLE: state_n = ARM;
        ARM: begin
          // first edge only opens the measurement window
          if (rise) begin
            state_n = TRACK;
            good_n  = '0;
          end
        end
        TRACK: begin
          if (rise) begin
            meas = 1'b1;
            if (in_win) begin
              good_n = good_cnt + GW'(1);
              if (good_n == LOCK_TGT) state_n = LOCKED;
            end else begin
              good_n = '0;
            end
          end else if (timeout) begin
            state_n = ARM;
          end
        end
        LOCKED: begin
          if (rise) begin
            meas = 1'b1;
            if (!in_win) state_n = FAULT;
          end else if (timeout) begin
            state_n = FAULT;
          end
        end
        FAULT: begin
          meas = rise;
          if (clr_fault) state_n = ARM;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      good_cnt   <= '0;
      cnt        <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      locked     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_n;
      good_cnt   <= good_n;
      period_vld <= meas;
      locked     <= (state_n == LOCKED);
      fault      <= (state_n == FAULT);
      if (meas) period <= cnt;
      if (!en || state == IDLE) cnt <= '0;
      else if (rise)            cnt <= CNT_W'(1);
      else if (!timeout)        cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef FREQ_MON_HIST_EN
  always_ff @(posedge clk) begin
    if (!rst || !en || clr_fault) begin
      min_period <= '1;
      max_period <= '0;
    end else if (meas) begin
      if (cnt < min_period) min_period <= cnt;
      if (cnt > max_period) max_period <= cnt;
    end
  end
`endif

endmodule

// File: doc/freq_monitor.md
Name: freq_monitor

Overview:
- Downstream consumer of the frequency-divider output in the same clock domain.
- Samples the divided clock `clkout` (fed in as `sig_in`) on `clk` and measures the period between rising edges in `clk` cycles.
- Compares each measured period against a programmed expected period and tolerance.
- Reports measurements, lock and a sticky fault; used as a self-check on every divider instance.

Parameters:
- CNT_W, 8, width of period counter, expected period, tolerance and reported period.
- SYNC_STAGES, 2, synchronizer flops on sig_in (minimum 2).
- LOCK_CNT, 4, consecutive in-window periods required to declare lock.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset; sampled only on the clk rising edge.
- en  input  1  monitor enable; 0 forces IDLE.
- clr_fault  input  1  single-cycle pulse; leaves FAULT.
- sig_in  input  1  monitored divided clock (divider clkout).
- exp_period  input  CNT_W  expected period in clk cycles; quasi-static while en=1.
- tol  input  CNT_W  allowed absolute deviation.
- period  output  CNT_W  last measured period.
- period_vld  output  1  one-cycle pulse when `period` updates.
- locked  output  1  high in LOCKED.
- fault  output  1  high in FAULT.

Behaviour:
- Reset:
  - All flops cleared on the clk edge where rst=0: sync chain, prev, cnt, good_cnt, period, period_vld, locked, fault.
  - State returns to IDLE.
  - rst low mid-operation aborts everything the same way; outputs are 0 from the following cycle.
- Input path:
  - sig_in passes through SYNC_STAGES flops.
  - rise = sync_out & ~prev.
- Counter cnt (CNT_W bits):
  - Loads 1 on rise.
  - Otherwise increments, saturating at 2^CNT_W-1; saturation = timeout.
  - Held at 0 in IDLE.
- Measurement:
  - On rise in TRACK or LOCKED: period<=cnt, period_vld<=1 for one cycle.
  - A rise in ARM only starts counting; no period is reported.
- Window check: in_win = |cnt - exp_period| <= tol, computed at CNT_W+1 bits signed, no wrap.
- Latency (SYNC_STAGES=2): period_vld is high in the cycle after the 3rd clk edge, counting the edge that first samples sig_in high as edge 1.
- FSM states: IDLE, ARM, TRACK, LOCKED, FAULT. en=0 moves any state to IDLE and clears good_cnt, cnt and flags.
  - IDLE: en=1 -> ARM.
  - ARM: rise -> TRACK with good_cnt=0.
  - TRACK:
    - rise & in_win -> good_cnt++; when good_cnt reaches LOCK_CNT -> LOCKED.
    - rise & ~in_win -> good_cnt=0, stay in TRACK.
    - timeout -> ARM.
  - LOCKED:
    - rise & ~in_win -> FAULT.
    - timeout -> FAULT.
    - rise & in_win -> stay.
  - FAULT:
    - Sticky; period still updates.
    - clr_fault -> ARM.
- Simultaneous events:
  - en=0 has priority over clr_fault and rise.
  - rise and timeout in the same cycle: rise wins. The counter saturates one cycle before the next increment, so a rise at exactly 2^CNT_W-1 is a valid period.
- locked and fault are registered, decoded from the next state, and never high together.

Optional Feature:
- Macro: FREQ_MON_HIST_EN.
- Defined:
  - Adds outputs min_period and max_period (CNT_W each), updated on every period_vld.
  - Reset to all-ones and zero respectively.
  - Cleared the same way on clr_fault or en=0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package freq_mon_pkg holds:
  - State enum type (IDLE, ARM, TRACK, LOCKED, FAULT).
  - Default-width constant.
  - Function computing the absolute difference at CNT_W+1 bits.
- One sub-module, sync_edge_det: parameterised SYNC_STAGES synchronizer plus prev flop; outputs rise; same clk/rst.

Test Plan:
- exp_period=4, tol=0, sig_in square wave of period 4 -> period_vld every 4 cycles with period=4; locked=1 after the 4th in-window measurement; fault=0.
- Locked, then one period of 3 injected -> period=3, fault=1 next cycle, locked=0; fault persists until a clr_fault pulse, then state is ARM and relock takes 4 good periods.
- Locked, sig_in held low (CNT_W=8) -> fault=1 one cycle after cnt reaches 255; never lock during TRACK timeout, which returns to ARM.
- tol=1, exp_period=4, periods alternating 5 and 3 -> all in window, lock achieved; tol=0 with the same stimulus -> good_cnt keeps clearing, never locks.
- rst driven low for 1 cycle while locked -> all outputs 0 next cycle, state IDLE; rst high with en=1 -> ARM, first rise produces no period_vld.
- en dropped in FAULT with clr_fault asserted in the same cycle -> IDLE, fault=0; with FREQ_MON_HIST_EN, periods 4,6,3 give min=3, max=6.
